// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: 2-flop synchronizer, 16x oversample tick divider,
// start-bit glitch reject, mid-bit sampling, frame-error and break handling.
module uart_rx_frontend #(
    parameter logic [9:0] DIV = 10'd325
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [9:0] DIV_LAST = DIV - 10'd1;

    state_t      state;
    logic        sync_1;
    logic        rx_s;
    logic [9:0]  div_cnt;
    logic [3:0]  smp_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        tick;
    logic        start_det;
    logic        mid_start;
    logic        bit_end;

    assign tick      = (div_cnt == DIV_LAST);
    assign start_det = (state == IDLE) && rx_en && !rx_s;
    assign mid_start = tick && (smp_cnt == 4'd7);
    assign bit_end   = tick && (smp_cnt == 4'd15);

    // Synchronizer flops reset to the idle-high line level so no false start
    // is seen as reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours (rx_s takes the old sync_1).
            sync_1 <= UART_RX;
            rx_s   <= sync_1;
        end
    end

    // Free-running divider and sample counter, re-phased to the falling start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= 10'd0;
            smp_cnt <= 4'd0;
        end else if (start_det) begin
            div_cnt <= 10'd0;
            smp_cnt <= 4'd0;
        end else if (tick) begin
            div_cnt <= 10'd0;
            if (state == START && smp_cnt == 4'd7)
                smp_cnt <= 4'd0;
            else
                smp_cnt <= smp_cnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_idx   <= 3'd0;
            // NOTE: the 8-bit shift register is plain flops, not a RAM, so it is
            // reset along with the rest to give a defined state after reset.
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    // Mid-start-bit check: a line already high again was a glitch.
                    if (mid_start) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (rx_s) begin
                            rx_data   <= shift_reg;
                            rx_status <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Line held low after a bad stop: wait for idle before re-arming.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at DIV=4 (64 clk per bit): a table of
// whole frames plus hand sequences for glitch, back-to-back and mid-frame reset.
module tb_uart_rx_frontend;

    localparam int BIT_CLK = 64;
    localparam int LAT_CLK = 608;
    localparam int B2B_CLK = 640;

    logic       clk;
    logic       reset;
    logic       UART_RX;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       busy;

    uart_rx_frontend #(.DIV(10'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: monotonic counters sampled on the falling edge, read as deltas.
    int         st_cnt = 0;
    int         fe_cnt = 0;
    int         busy_cyc = 0;
    int         overlap = 0;
    int         start_cyc = 0;
    int         last_lat = -1;
    int         last_st_cyc = 0;
    int         prev_st_cyc = 0;
    logic [7:0] last_st_data = 8'h00;
    logic [7:0] prev_st_data = 8'h00;
    logic       busy_d = 1'b0;

    always @(negedge clk) begin
        if (busy && !busy_d)
            start_cyc = cyc;
        if (rx_status) begin
            st_cnt++;
            prev_st_cyc  = last_st_cyc;
            prev_st_data = last_st_data;
            last_st_cyc  = cyc;
            last_st_data = rx_data;
            last_lat     = cyc - start_cyc;
        end
        if (frame_err)
            fe_cnt++;
        if (rx_status && frame_err)
            overlap++;
        if (busy)
            busy_cyc++;
        busy_d = busy;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold the line at v for n clocks; returns 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic en_mid);
        drive_bit(1'b0, BIT_CLK);
        rx_en = en_mid;
        for (int b = 0; b < 8; b++)
            drive_bit(d[b], BIT_CLK);
        drive_bit(stop_v, BIT_CLK);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       en;
        logic       en_mid;
        int         exp_st;
        int         exp_fe;
        logic [7:0] exp_rx;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s0, f0, b0;

        //          data   stop  en    en_mid st fe rx_data busy
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1, 0, 8'hA5, 1};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 0, 1, 8'hA5, 1};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 0, 0, 8'hA5, 0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 1, 0, 8'h81, 1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1, 0, 8'h00, 1};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1, 0, 8'hFF, 1};

        reset   = 1'b0;
        UART_RX = 1'b1;
        rx_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_status", rx_status, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        drive_bit(1'b1, 10);
        check("post_rst_busy", busy, 0);
        check("post_rst_rx_data", rx_data, 8'h00);

        for (int i = 0; i < 6; i++) begin
            rx_en = vecs[i].en;
            s0 = st_cnt;
            f0 = fe_cnt;
            b0 = busy_cyc;
            send_frame(vecs[i].data, vecs[i].stop_v, vecs[i].en_mid);
            if (!vecs[i].stop_v) begin
                drive_bit(1'b0, BIT_CLK);
                check($sformatf("v%0d_break_busy", i), busy, 1);
            end
            drive_bit(1'b1, 40);
            check($sformatf("v%0d_status_pulses", i), st_cnt - s0, vecs[i].exp_st);
            check($sformatf("v%0d_ferr_pulses", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_busy_seen", i), (busy_cyc > b0) ? 1 : 0, vecs[i].exp_busy);
            check($sformatf("v%0d_busy_idle", i), busy, 0);
            if (vecs[i].exp_st == 1)
                check($sformatf("v%0d_latency", i), last_lat, LAT_CLK);
        end

        // Short low pulse: start detected, then rejected at mid-start-bit.
        rx_en = 1'b1;
        s0 = st_cnt;
        f0 = fe_cnt;
        b0 = busy_cyc;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 100);
        check("glitch_busy_seen", (busy_cyc > b0) ? 1 : 0, 1);
        check("glitch_status", st_cnt - s0, 0);
        check("glitch_ferr", fe_cnt - f0, 0);
        check("glitch_rx_data", rx_data, 8'hFF);
        check("glitch_busy_idle", busy, 0);

        // Back-to-back frames with no idle gap between stop and next start.
        s0 = st_cnt;
        f0 = fe_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive_bit(1'b1, 40);
        check("b2b_status_pulses", st_cnt - s0, 2);
        check("b2b_ferr", fe_cnt - f0, 0);
        check("b2b_first_data", prev_st_data, 8'h00);
        check("b2b_second_data", last_st_data, 8'hFF);
        check("b2b_interval", last_st_cyc - prev_st_cyc, B2B_CLK);
        check("b2b_latency", last_lat, LAT_CLK);

        // Reset in the middle of a byte: asynchronous clear, then a clean frame.
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        drive_bit(1'b0, 30);
        reset = 1'b0;
        #2;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_rx_status", rx_status, 0);
        check("midrst_frame_err", frame_err, 0);
        UART_RX = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_bit(1'b1, 20);
        check("midrst_busy_after", busy, 0);
        s0 = st_cnt;
        f0 = fe_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        drive_bit(1'b1, 40);
        check("after_rst_status", st_cnt - s0, 1);
        check("after_rst_ferr", fe_cnt - f0, 0);
        check("after_rst_rx_data", rx_data, 8'h81);
        check("after_rst_latency", last_lat, LAT_CLK);

        check("status_ferr_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter DIV, default 10'd325, meaning clk cycles per 16x oversample tick (9600 baud x16 at 50 MHz).
REQ-002 reset  input  1  reset, asynchronous, active-low.
REQ-003 clk  input  1  single system clock; all state in this clock domain.
REQ-004 UART_RX  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 rx_en  input  1  receive enable; driven by the peripheral's UART receive-enable control bit.
REQ-006 rx_data  output  8  last correctly framed byte.
REQ-007 rx_status  output  1  one-clk pulse: new byte valid on rx_data.
REQ-008 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 UART_RX SHALL pass through a 2-flop synchronizer; only the synchronized value rx_s is used internally.
REQ-011 Divider counter div_cnt (10 bits) SHALL count 0..DIV-1 and wrap; tick is high for the one clk in which div_cnt==DIV-1.
REQ-012 Sample counter smp_cnt (4 bits) SHALL increment on each tick and wrap 15->0.
REQ-013 States: IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: when rx_en=1 and rx_s=0 -> START; div_cnt and smp_cnt SHALL be cleared in that same clk.
REQ-015 IDLE with rx_en=0 SHALL ignore the line.
REQ-016 START: on the 8th tick (smp_cnt==7 at tick), rx_s=0 -> DATA with smp_cnt cleared and bit index 0; rx_s=1 -> IDLE (glitch reject, no output pulse).
REQ-017 DATA: on every 16th tick (smp_cnt==15 at tick), shift rx_s into bit[index], LSB first; after index 7 -> STOP.
REQ-018 STOP: on the 16th tick, rx_s=1 -> rx_data loaded from the shift register, rx_status pulsed for 1 clk, -> IDLE.
REQ-019 STOP: on the 16th tick, rx_s=0 -> frame_err pulsed for 1 clk, rx_data unchanged, -> BREAK.
REQ-020 BREAK: stays until rx_s=1, then -> IDLE; a new start SHALL NOT be detected while in BREAK.
REQ-021 Latency: stop sample, and therefore the rx_status pulse, occurs exactly 152*DIV clk after the IDLE->START clk; the start edge reaches rx_s 2 clk after the line edge.
REQ-022 rx_en deasserted mid-frame SHALL NOT abort the frame; it only gates start detection in IDLE.
REQ-023 rx_data SHALL hold its value until the next good frame; rx_status and frame_err SHALL never be high in the same clk.
REQ-024 Back-to-back frames: a start bit immediately following the stop sample SHALL be accepted, since IDLE is entered the clk after the stop sample.

Reset
REQ-025 reset=0 SHALL asynchronously force: state IDLE, div_cnt=0, smp_cnt=0, bit index 0, shift register 0, rx_data=8'h00, rx_status=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release, the first frame begins at the next falling edge seen in IDLE.

Verification (DIV=4: bit time 64 clk)
REQ-027 Send 8'hA5 (8N1) with rx_en=1 -> rx_status high for exactly 1 clk, 608 clk after START entry; rx_data=8'hA5; frame_err stays 0.
REQ-028 Line low pulse of 20 clk from idle -> START then IDLE; no rx_status or frame_err pulse; rx_data unchanged.
REQ-029 Send 8'h3C with a low stop bit -> frame_err 1-clk pulse; rx_data keeps its previous value; busy stays high until the line returns high.
REQ-030 Send 8'h00 then 8'hFF back-to-back (no idle gap) -> two rx_status pulses 640 clk apart, carrying 8'h00 then 8'hFF.
REQ-031 rx_en=0, send 8'h55 -> no pulse, busy=0; reset pulse mid-byte after rx_en=1 -> all outputs at reset values; next 8'h81 received correctly.
